// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage bus between the pipeline and the HI/LO multiply/divide unit.
// The pipeline drives the master side; the unit is the slave.
interface hilo_muldiv_unit_if;
  logic        start;
  logic [4:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wr_data;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op, src_a, src_b, flush, mthi_we, mtlo_we, wr_data, rd_req, rd_sel,
    input  rd_data, busy, done, stall
  );

  modport slave (
    input  start, op, src_a, src_b, flush, mthi_we, mtlo_we, wr_data, rd_req, rd_sel,
    output rd_data, busy, done, stall
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle mult/div unit that owns the HI/LO registers and serves MFHI/MFLO.
// Optional macro HILO_BYPASS_EN forwards same-cycle MTHI/MTLO data to rd_data.
module hilo_muldiv_unit #(
  parameter int ITER = 32
) (
  input logic clk,
  input logic rst_n,
  hilo_muldiv_unit_if.slave bus
);

  localparam logic [4:0] OP_DIV   = 5'b00011;
  localparam logic [4:0] OP_MULT  = 5'b00100;
  localparam logic [4:0] OP_DIVU  = 5'b10100;
  localparam logic [4:0] OP_MULTU = 5'b10101;

  // ITERATE is the ITER phase; renamed so it does not clash with the parameter
  typedef enum logic [1:0] {IDLE, PREP, ITERATE, FIX} stateT;

  stateT       state;
  stateT       nextState;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] srcAReg;
  logic [31:0] srcBReg;
  logic        isDiv;
  logic        isSigned;
  logic        negQ;
  logic        negR;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [31:0] remReg;
  logic [4:0]  count;
  logic        doneReg;

  logic        validOp;
  logic        accept;
  logic        hiWrite;
  logic        loWrite;
  logic        fixWrite;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [32:0] mulSum;
  logic [32:0] remShift;
  logic        remGe;
  logic [31:0] remSub;
  logic [63:0] prodSigned;
  logic [31:0] quoSigned;
  logic [31:0] remSigned;

  assign validOp  = (bus.op == OP_DIV) || (bus.op == OP_MULT) ||
                    (bus.op == OP_DIVU) || (bus.op == OP_MULTU);
  assign accept   = (state == IDLE) && bus.start && validOp && !bus.flush;
  assign hiWrite  = (state == IDLE) && !accept && bus.mthi_we;
  assign loWrite  = (state == IDLE) && !accept && bus.mtlo_we;
  assign fixWrite = (state == FIX) && !bus.flush;

  assign absA = (isSigned && srcAReg[31]) ? -srcAReg : srcAReg;
  assign absB = (isSigned && srcBReg[31]) ? -srcBReg : srcBReg;

  // The true remainder is always below the divisor, so a 32-bit subtract suffices
  assign mulSum   = {1'b0, acc[63:32]} + {1'b0, opnd};
  assign remShift = {remReg, acc[31]};
  assign remGe    = remShift >= {1'b0, opnd};
  assign remSub   = remShift[31:0] - opnd;

  assign prodSigned = negQ ? -acc : acc;
  assign quoSigned  = negQ ? -acc[31:0] : acc[31:0];
  assign remSigned  = negR ? -remReg : remReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = PREP;
      PREP:    nextState = ITERATE;
      ITERATE: if (count == 5'd0) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (bus.flush && (state != IDLE)) nextState = IDLE;
  end

  // Operand capture, sign preparation and the one-bit-per-cycle iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srcAReg  <= '0;
      srcBReg  <= '0;
      isDiv    <= 1'b0;
      isSigned <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      remReg   <= '0;
      count    <= '0;
    end else begin
      if (accept) begin
        srcAReg  <= bus.src_a;
        srcBReg  <= bus.src_b;
        isDiv    <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        isSigned <= (bus.op == OP_DIV) || (bus.op == OP_MULT);
      end
      case (state)
        PREP: begin
          negQ   <= isSigned && (srcAReg[31] ^ srcBReg[31]);
          negR   <= isSigned && srcAReg[31];
          opnd   <= isDiv ? absB : absA;
          acc    <= {32'd0, isDiv ? absA : absB};
          remReg <= '0;
          count  <= 5'(ITER - 1);
        end
        ITERATE: begin
          count <= count - 5'd1;
          if (isDiv) begin
            acc[31:0] <= {acc[30:0], remGe};
            remReg    <= remGe ? remSub : remShift[31:0];
          end else if (acc[0]) begin
            acc <= {mulSum, acc[31:1]};
          end else begin
            acc <= {1'b0, acc[63:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: result write in FIX, otherwise MTHI/MTLO when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= fixWrite;
      if (fixWrite) begin
        if (!isDiv) begin
          hiReg <= prodSigned[63:32];
          loReg <= prodSigned[31:0];
        end else if (opnd == 32'd0) begin
          hiReg <= srcAReg;
          loReg <= 32'hFFFF_FFFF;
        end else begin
          hiReg <= remSigned;
          loReg <= quoSigned;
        end
      end else begin
        if (hiWrite) hiReg <= bus.wr_data;
        if (loWrite) loReg <= bus.wr_data;
      end
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = doneReg;
  assign bus.stall = bus.busy && (bus.rd_req || bus.start || bus.mthi_we || bus.mtlo_we);

  always_comb begin
    bus.rd_data = bus.rd_sel ? hiReg : loReg;
`ifdef HILO_BYPASS_EN
    if (rst_n && bus.rd_req && bus.rd_sel && hiWrite)  bus.rd_data = bus.wr_data;
    if (rst_n && bus.rd_req && !bus.rd_sel && loWrite) bus.rd_data = bus.wr_data;
`endif
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers and serves MFHI/MFLO reads.
- Receiving end of the ALU's mul/div op codes: the execute stage issues an op here instead of getting a combinational result.
- Sits beside the ALU in EX and drives a stall back to the pipeline control.

Parameters:
- ITER, 32, iteration cycles (one operand bit per cycle); must equal operand width 32.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue op; sampled only in IDLE
- op  in  5  5'b00011 div, 5'b00100 mult, 5'b10100 divu, 5'b10101 multu; any other code with start is ignored
- src_a  in  32  dividend / multiplicand, sampled with start
- src_b  in  32  divisor / multiplier, sampled with start
- flush  in  1  abort in-flight op (exception)
- mthi_we  in  1  write HI from wr_data
- mtlo_we  in  1  write LO from wr_data
- wr_data  in  32  MTHI/MTLO data
- rd_req  in  1  MFHI/MFLO in EX
- rd_sel  in  1  0=LO, 1=HI
- rd_data  out  32  selected register value
- busy  out  1  op in flight
- done  out  1  one-cycle pulse; HI/LO just updated
- stall  out  1  busy & (rd_req | start | mthi_we | mtlo_we)

Behaviour:
- Reset (async, rst_n=0): HI=0, LO=0, state=IDLE, busy=0, done=0, datapath regs cleared. rd_data=0 while in reset.
- States: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE:
  - start with a valid op latches the operands and op code, then goes to PREP; busy=1 from the next cycle.
- PREP (1 cycle):
  - Signed ops: take absolute values; record the quotient/product sign (a^b) and the remainder sign (a).
  - Unsigned ops: pass the operands through.
- ITER (ITER cycles, 5-bit counter 31 down to 0):
  - mult: shift-add over a 64-bit accumulator.
  - div: restoring division using a 33-bit partial remainder.
- FIX (1 cycle): apply signs, write HI/LO at the end of the cycle, return to IDLE.
  - mult: HI=prod[63:32], LO=prod[31:0].
  - div: LO=quotient, HI=remainder.
- Latency: start sampled at edge N; busy high for cycles N+1..N+34; HI/LO valid and done=1 in cycle N+35.
- Arithmetic:
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) -> LO=0x80000000, HI=0.
  - Divide by zero (div or divu) -> LO=0xFFFFFFFF, HI=src_a. Runs the full latency; no trap.
- start while busy: ignored. stall holds the issuing instruction, which must re-present start after busy falls.
- mthi_we/mtlo_we:
  - Written at the clock edge when IDLE and not starting.
  - Ignored while busy (stall asserted).
  - Same cycle as an accepted start: start wins and the write is dropped.
  - mthi_we and mtlo_we together: both registers are written.
- flush:
  - Any non-IDLE state goes to IDLE on the next edge; busy=0, no done, HI/LO unchanged.
  - flush in IDLE alongside start: start is not accepted.
- rd_data = rd_sel ? HI : LO, combinational from the registers.
  - While busy it shows the old value; stall keeps the reader from consuming it.
- done is never asserted in the same cycle as busy.

Optional Feature:
- Macro HILO_BYPASS_EN.
- Defined: when mthi_we/mtlo_we is accepted in the same cycle as rd_req with a matching rd_sel, rd_data returns wr_data combinationally. In done's cycle, rd_data returns the newly written value, with no extra cycle.
- Undefined: rd_data always comes from the HI/LO registers. The reader sees the new value from the cycle after the write; the pipeline must avoid this hazard.

Test Plan:
- Reset mid-ITER (rst_n low at cycle 10 of a mult) -> HI=LO=0, busy=0 immediately, no done pulse.
- mult 0xFFFFFFFE x 0x00000003 -> after 35 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 0 -> LO=0xFFFFFFFF, HI=7.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, done exactly at cycle N+35.
- rd_req=1 with rd_sel=1 during busy -> stall=1 every busy cycle, stall=0 in the done cycle. mthi_we during busy -> HI not modified.
- flush at cycle 20 of divu (HI/LO previously 0x11/0x22) -> busy drops next cycle, HI=0x11, LO=0x22, no done. A new start is then accepted normally.
